// File: rtl/conv_out_quant.sv
// Requantizes systolic-array accumulators to int8 over a layer of (channel group, column, row) beats.
// Define CONV_OUT_RELU_EN to clamp negative results to zero ahead of saturation.
module conv_out_quant #(
  parameter int LANES = 8,
  parameter int ACC_W = 32,
  parameter int DIM_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DIM_W-1:0]       out_channel,
  input  logic [DIM_W-1:0]       matrix_col,
  input  logic [DIM_W-1:0]       matrix_row,
  input  logic [15:0]            scale,
  input  logic [4:0]             shift,
  input  logic [LANES*ACC_W-1:0] s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [LANES*8-1:0]     m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   busy,
  output logic                   layer_end
);

  localparam int PW = ACC_W + 17;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]             state;
  logic [DIM_W-1:0]       start_grp;
  logic [DIM_W-1:0]       grp_lim, col_lim, row_lim;
  logic [DIM_W-1:0]       grp_cnt, col_cnt, row_cnt;
  logic [15:0]            scale_q;
  logic [4:0]             shift_q;
  logic                   en, accept, grp_end, col_end, row_end, in_last;
  logic                   vld_p1, last_p1, vld_p2, last_p2;
  logic signed [PW-1:0]   prod_p0 [LANES];
  logic signed [PW-1:0]   prod_p1 [LANES];
  logic [LANES*8-1:0]     quant_p1;
  logic [LANES*8-1:0]     data_p2;

  // Round half up, arithmetic shift, optional ReLU, then clamp to int8.
  function automatic logic signed [7:0] requant(input logic signed [PW-1:0] p,
                                                input logic [4:0] sh);
    logic signed [PW:0] r;
    r = {p[PW-1], p};
    if (sh != 5'd0) r = r + ((PW+1)'(1) << (sh - 5'd1));
    r = r >>> sh;
`ifdef CONV_OUT_RELU_EN
    if (r < 0) r = '0;
`endif
    if (r > 127) return 8'sd127;
    if (r < -128) return -8'sd128;
    return r[7:0];
  endfunction

  assign start_grp = out_channel / DIM_W'(LANES);
  assign en        = !vld_p2 || m_ready;
  assign s_ready   = (state == S_RUN) && en;
  assign accept    = s_valid && s_ready;
  assign grp_end   = (grp_cnt == grp_lim - DIM_W'(1));
  assign col_end   = (col_cnt == col_lim - DIM_W'(1));
  assign row_end   = (row_cnt == row_lim - DIM_W'(1));
  assign in_last   = grp_end && col_end && row_end;

  assign busy      = (state != S_IDLE);
  assign layer_end = (state == S_DONE);
  assign m_valid   = vld_p2;
  assign m_last    = vld_p2 && last_p2;
  assign m_data    = data_p2;

  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      grp_lim <= start_grp;
      col_lim <= matrix_col;
      row_lim <= matrix_row;
      scale_q <= scale;
      shift_q <= shift;
    end
  end

  // Beat counters: channel group innermost, then column, then row.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      grp_cnt <= '0;
      col_cnt <= '0;
      row_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            grp_cnt <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
            if (start_grp == '0 || matrix_col == '0 || matrix_row == '0) state <= S_DONE;
            else state <= S_RUN;
          end
        end
        S_RUN: begin
          if (accept) begin
            if (grp_end) begin
              grp_cnt <= '0;
              if (col_end) begin
                col_cnt <= '0;
                if (row_end) row_cnt <= '0;
                else row_cnt <= row_cnt + DIM_W'(1);
              end else begin
                col_cnt <= col_cnt + DIM_W'(1);
              end
            end else begin
              grp_cnt <= grp_cnt + DIM_W'(1);
            end
            if (in_last) state <= S_DRAIN;
          end
        end
        S_DRAIN: if (m_valid && m_ready && m_last) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_p0[i] = PW'(signed'(s_data[i*ACC_W +: ACC_W])) * PW'(signed'({1'b0, scale_q}));
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      quant_p1[i*8 +: 8] = requant(prod_p1[i], shift_q);
    end
  end

  // Stage boundary p0 -> p1 (multiply) and p1 -> p2 (round/shift/saturate).
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
    end else if (en) begin
      vld_p1  <= accept;
      last_p1 <= accept && in_last;
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (en) prod_p1 <= prod_p0;
  end

  always_ff @(posedge clk) begin
    if (rst) data_p2 <= '0;
    else if (en) data_p2 <= quant_p1;
  end

endmodule

// File: tb/tb_conv_out_quant.sv
// Randomized bench for conv_out_quant: a queue-based scoreboard fed from an arithmetic requant model.
module tb_conv_out_quant;
  localparam int LANES = 8;
  localparam int ACC_W = 32;
  localparam int DIM_W = 16;

  logic                   clk = 1'b0;
  logic                   rst, start, s_valid, s_ready, m_valid, m_ready, m_last, busy, layer_end;
  logic [DIM_W-1:0]       out_channel, matrix_col, matrix_row;
  logic [15:0]            scale;
  logic [4:0]             shift;
  logic [LANES*ACC_W-1:0] s_data;
  logic [LANES*8-1:0]     m_data;

  always #5 clk = ~clk;

  conv_out_quant #(.LANES(LANES), .ACC_W(ACC_W), .DIM_W(DIM_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .out_channel(out_channel), .matrix_col(matrix_col), .matrix_row(matrix_row),
    .scale(scale), .shift(shift),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .layer_end(layer_end)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [LANES*8-1:0] exp_data_q[$];
  bit                 exp_last_q[$];
  int cfg_total = 0, cfg_scale = 0, cfg_shift = 0;
  int in_cnt = 0, out_cnt = 0, lend_n = 0, lend_cyc = -1, last_cyc = -1;
  int first_in_cyc = -1, first_out_cyc = -1, st_cyc = 0;
  logic [LANES*8-1:0] last_out = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference requant with wide integer arithmetic.
  function automatic int model_requant(input longint acc, input longint sc, input int sh);
    longint p;
    p = acc * sc;
    if (sh > 0) p = p + (longint'(1) << (sh - 1));
    p = p >>> sh;
`ifdef CONV_OUT_RELU_EN
    if (p < 0) p = 0;
`endif
    if (p > 127) p = 127;
    if (p < -128) p = -128;
    return int'(p);
  endfunction

  function automatic logic [LANES*8-1:0] model_beat(input logic [LANES*ACC_W-1:0] d,
                                                    input int sc, input int sh);
    logic [LANES*8-1:0] r;
    logic signed [ACC_W-1:0] a;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      a = d[i*ACC_W +: ACC_W];
      r[i*8 +: 8] = 8'(model_requant(longint'(a), longint'(sc), sh));
    end
    return r;
  endfunction

  // Monitor: scoreboard every output handshake, record every input handshake.
  initial begin
    logic [LANES*8-1:0] e;
    bit l;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst !== 1'b0) continue;
      if (m_valid && m_ready) begin
        out_cnt++;
        last_out = m_data;
        if (out_cnt == 1) first_out_cyc = cyc;
        if (exp_data_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_beat: got beat %0d, expected none", out_cnt);
        end else begin
          e = exp_data_q.pop_front();
          l = exp_last_q.pop_front();
          check("m_data", 64'(m_data), 64'(e));
          check("m_last", 64'(m_last), 64'(l));
          if (m_last) last_cyc = cyc;
        end
      end
      if (layer_end) begin
        lend_n++;
        lend_cyc = cyc;
      end
      if (s_valid && s_ready) begin
        if (in_cnt == 0) first_in_cyc = cyc;
        exp_data_q.push_back(model_beat(s_data, cfg_scale, cfg_shift));
        exp_last_q.push_back(in_cnt == cfg_total - 1);
        in_cnt++;
      end
    end
  end

  task automatic drive_cycle(input int vp, input int rp, input int mode, input int cval);
    @(posedge clk);
    #1;
    s_valid = ($urandom_range(99) < vp);
    m_ready = ($urandom_range(99) < rp);
    for (int i = 0; i < LANES; i++) begin
      case (mode)
        0: s_data[i*ACC_W +: ACC_W] = ACC_W'(i);
        1: s_data[i*ACC_W +: ACC_W] = ACC_W'(cval);
        2: s_data[i*ACC_W +: ACC_W] = ACC_W'(int'($urandom_range(4000)) - 2000);
        default: s_data[i*ACC_W +: ACC_W] = ACC_W'($urandom);
      endcase
    end
  endtask

  task automatic start_layer(input int oc, input int col, input int row, input int sc, input int sh);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    start = 1'b1;
    out_channel = DIM_W'(oc);
    matrix_col = DIM_W'(col);
    matrix_row = DIM_W'(row);
    scale = 16'(sc);
    shift = 5'(sh);
    cfg_total = (oc / LANES) * col * row;
    cfg_scale = sc;
    cfg_shift = sh;
    in_cnt = 0;
    out_cnt = 0;
    first_in_cyc = -1;
    first_out_cyc = -1;
    last_cyc = -1;
    st_cyc = cyc + 1;
    @(posedge clk);
    #1;
    start = 1'b0;
    out_channel = DIM_W'($urandom);
    matrix_col = DIM_W'($urandom);
    matrix_row = DIM_W'($urandom);
    scale = 16'($urandom);
    shift = 5'($urandom);
  endtask

  task automatic run_layer(input string tag, input int oc, input int col, input int row,
                           input int sc, input int sh, input int vp, input int rp,
                           input int mode, input int cval, input int spur);
    int n0;
    n0 = lend_n;
    start_layer(oc, col, row, sc, sh);
    for (int i = 0; i < 5000 && lend_n == n0; i++) begin
      drive_cycle(vp, rp, mode, cval);
      start = (i == spur);
      if (start) begin
        out_channel = DIM_W'(LANES);
        matrix_col = DIM_W'(1);
        matrix_row = DIM_W'(1);
      end
    end
    start = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    check({tag, "_layer_end_count"}, 64'(lend_n - n0), 64'(1));
    check({tag, "_beats"}, 64'(out_cnt), 64'(cfg_total));
    check({tag, "_queue_empty"}, 64'(exp_data_q.size()), 64'(0));
    if (cfg_total > 0) check({tag, "_layer_end_after_last"}, 64'(lend_cyc), 64'(last_cyc + 1));
  endtask

  initial begin
    int n0;
    bit saw_ready;
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    out_channel = '0; matrix_col = '0; matrix_row = '0; scale = '0; shift = '0; s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_m_valid", 64'(m_valid), 64'(0));
    check("reset_m_last", 64'(m_last), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_layer_end", 64'(layer_end), 64'(0));
    check("reset_s_ready", 64'(s_ready), 64'(0));
    check("reset_m_data", 64'(m_data), 64'(0));

    // Model pins against hand-computed values.
    check("pin_sat_pos", 64'(model_requant(1000, 3, 4)), 64'(127));
`ifdef CONV_OUT_RELU_EN
    check("pin_sat_neg", 64'(model_requant(-1000, 3, 4)), 64'(0));
`else
    check("pin_sat_neg", 64'(model_requant(-1000, 3, 4)), 64'(-128));
`endif
    check("pin_round_pos", 64'(model_requant(5, 1, 1)), 64'(3));
    check("pin_round_neg", 64'(model_requant(-5, 1, 1)), 64'(-2));

    // Full-rate layer of 112 beats, with a start pulse while busy.
    run_layer("basic", 32, 14, 2, 1, 0, 100, 100, 0, 0, 3);
    check("basic_last_data", 64'(last_out), 64'h0706050403020100);
    check("basic_latency", 64'(first_out_cyc - first_in_cyc), 64'(2));
    check("basic_throughput", 64'(last_cyc - first_out_cyc), 64'(111));

    run_layer("sat_pos", 8, 2, 1, 3, 4, 100, 100, 1, 1000, -1);
    check("sat_pos_value", 64'(last_out), {8{8'h7f}});
    run_layer("sat_neg", 8, 2, 1, 3, 4, 100, 100, 1, -1000, -1);
`ifdef CONV_OUT_RELU_EN
    check("sat_neg_value", 64'(last_out), 64'(0));
`else
    check("sat_neg_value", 64'(last_out), {8{8'h80}});
`endif
    run_layer("round_pos", 16, 1, 1, 1, 1, 100, 100, 1, 5, -1);
    check("round_pos_value", 64'(last_out), {8{8'h03}});
    run_layer("round_neg", 16, 1, 1, 1, 1, 100, 100, 1, -5, -1);
`ifdef CONV_OUT_RELU_EN
    check("round_neg_value", 64'(last_out), 64'(0));
`else
    check("round_neg_value", 64'(last_out), {8{8'hfe}});
`endif

    // Random backpressure and random input valid.
    for (int t = 0; t < 6; t++) begin
      run_layer("rand", LANES * int'($urandom_range(1, 4)), int'($urandom_range(1, 6)),
                int'($urandom_range(1, 3)), int'($urandom_range(0, 400)),
                int'($urandom_range(0, 12)), 60, 50, 2, 0, 2);
    end
    run_layer("wide", 24, 3, 2, 65535, 31, 70, 50, 3, 0, -1);
    run_layer("wide_mid", 16, 4, 2, int'($urandom_range(1, 65535)), 20, 70, 50, 3, 0, -1);

    // Zero dimension: straight to DONE, second start during busy ignored.
    n0 = lend_n;
    saw_ready = 1'b0;
    start_layer(32, 0, 2, 1, 0);
    check("zero_busy", 64'(busy), 64'(1));
    saw_ready = saw_ready | s_ready;
    start = 1'b1;
    out_channel = DIM_W'(32);
    matrix_col = DIM_W'(4);
    matrix_row = DIM_W'(1);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(100, 100, 0, 0);
      saw_ready = saw_ready | s_ready;
    end
    s_valid = 1'b0;
    check("zero_layer_end_count", 64'(lend_n - n0), 64'(1));
    check("zero_layer_end_latency", 64'(lend_cyc), 64'(st_cyc + 1));
    check("zero_no_ready", 64'(saw_ready), 64'(0));
    check("zero_idle_after", 64'(busy), 64'(0));
    check("zero_no_beats", 64'(out_cnt), 64'(0));

    // Reset in the middle of a layer.
    n0 = lend_n;
    start_layer(32, 14, 2, 1, 0);
    for (int i = 0; i < 2000 && out_cnt < 50; i++) drive_cycle(100, 100, 0, 0);
    check("rst_reached_beat50", 64'(out_cnt), 64'(50));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    s_valid = 1'b0;
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_m_last", 64'(m_last), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_layer_end", 64'(layer_end), 64'(0));
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_m_data", 64'(m_data), 64'(0));
    exp_data_q.delete();
    exp_last_q.delete();
    repeat (5) @(posedge clk);
    #1;
    check("rst_no_layer_end", 64'(lend_n - n0), 64'(0));
    run_layer("post_rst", 32, 14, 2, 7, 3, 80, 50, 2, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
